// File: rtl/dds_pkg.sv
// Shared widths, FSM state encoding and saturation constant for the DDS
// step estimator and its divider.
package dds_pkg;
    localparam int STEP_W   = 32;
    localparam int SAMPLE_W = 16;

    localparam logic [STEP_W-1:0] STEP_SAT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        SEEK,
        COUNT,
        DIV,
        DONE
    } state_t;
endpackage

// File: rtl/dds_restoring_div.sv
// Sequential restoring divider: one quotient bit per clock, DVD_W bits in total.
// The first bit is resolved on the start edge, so done rises DVD_W-1 cycles later.
module dds_restoring_div #(
    parameter int DVD_W = 33,
    parameter int DVS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);
    localparam int ITERS = DVD_W;
    localparam int CNT_W = $clog2(ITERS + 1);

    logic             run;
    logic [CNT_W-1:0] iter_left;
    logic [DVS_W-1:0] rem_p;
    logic [DVS_W-1:0] dvs_p;
    logic [DVD_W-1:0] dvd_sh;
    logic [DVD_W-1:0] quo;
    logic [DVS_W:0]   first_step;
    logic [DVS_W:0]   next_step;

    // Returns {quotient_bit, new_remainder}; the remainder always stays below the divisor.
    function automatic logic [DVS_W:0] rs_step(input logic [DVS_W-1:0] rem,
                                               input logic             bit_in,
                                               input logic [DVS_W-1:0] dvs);
        logic [DVS_W:0] part;
        logic [DVS_W:0] diff;
        part = {rem, bit_in};
        diff = part - {1'b0, dvs};
        if (part >= {1'b0, dvs})
            rs_step = {1'b1, diff[DVS_W-1:0]};
        else
            rs_step = {1'b0, part[DVS_W-1:0]};
    endfunction

    assign first_step = rs_step('0, dividend[DVD_W-1], divisor);
    assign next_step  = rs_step(rem_p, dvd_sh[DVD_W-1], dvs_p);

    always_ff @(posedge clk) begin
        if (!reset) begin
            run       <= 1'b0;
            iter_left <= '0;
        end else if (start) begin
            run       <= 1'b1;
            iter_left <= CNT_W'(ITERS - 1);
        end else if (run) begin
            if (iter_left == '0)
                run <= 1'b0;
            else
                iter_left <= iter_left - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rem_p  <= first_step[DVS_W-1:0];
            quo    <= {{(DVD_W-1){1'b0}}, first_step[DVS_W]};
            dvd_sh <= dividend << 1;
            dvs_p  <= divisor;
        end else if (run && iter_left != '0) begin
            rem_p  <= next_step[DVS_W-1:0];
            quo    <= {quo[DVD_W-2:0], next_step[DVS_W]};
            dvd_sh <= dvd_sh << 1;
        end
    end

    assign done     = run && (iter_left == '0);
    assign quotient = quo;
endmodule

// File: rtl/dds_step_estimator.sv
// Measures the period of an offset-binary waveform with a hysteresis comparator
// and converts it to a 32-bit DDS tuning word, Step = 2^32 / period.
module dds_step_estimator import dds_pkg::*; #(
    parameter logic [15:0] MIDPOINT = 16'h8000,
    parameter logic [15:0] HYST     = 16'h0400,
    parameter int          AVG_LOG2 = 0,
    parameter logic [31:0] TIMEOUT  = 32'd50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic [STEP_W-1:0]   step_out,
    output logic                step_valid,
    output logic                no_signal,
    output logic                busy
);
    localparam int DVD_W = STEP_W + 1 + AVG_LOG2;
    localparam int PER_W = AVG_LOG2 + 1;
    localparam int NAVG  = 1 << AVG_LOG2;

    localparam logic [16:0]         HI_SUM = {1'b0, MIDPOINT} + {1'b0, HYST};
    localparam logic [SAMPLE_W-1:0] HI_THR = HI_SUM[16] ? 16'hFFFF : HI_SUM[15:0];
    localparam logic [SAMPLE_W-1:0] LO_THR = (MIDPOINT >= HYST) ? (MIDPOINT - HYST) : 16'h0000;

    state_t             state;
    state_t             state_nxt;
    logic               lvl;
    logic               lvl_known;
    logic               evt_p1;
    logic               vld_p1;
    logic [STEP_W-1:0]  cnt;
    logic [STEP_W-1:0]  cnt_nxt;
    logic [PER_W-1:0]   per;
    logic [PER_W-1:0]   per_nxt;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               per_inc;
    logic               div_start;
    logic               div_done;
    logic               timeout_hit;
    logic               result_ld;
    logic               above_hi;
    logic               below_lo;
    logic [DVD_W-1:0]   quotient;
    logic [DVD_W-1:0]   dividend;

    function automatic logic [STEP_W-1:0] sat_step(input logic [DVD_W-1:0] q);
        logic [STEP_W-1:0] r;
        r = q[STEP_W-1:0];
        if (|q[DVD_W-1:STEP_W])
            r = STEP_SAT;
        return r;
    endfunction

    assign above_hi = (sample_in >= HI_THR);
    assign below_lo = (sample_in <= LO_THR);
    assign cnt_nxt  = cnt + 1'b1;
    assign per_nxt  = per + 1'b1;
    assign dividend = {1'b1, {(DVD_W-1){1'b0}}};
    assign busy     = (state == DIV);

    // Stage p1: comparator and registered rising-event detect
    always_ff @(posedge clk) begin
        if (!reset) begin
            lvl       <= 1'b0;
            lvl_known <= 1'b0;
            evt_p1    <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= sample_valid;
            evt_p1 <= sample_valid && lvl_known && !lvl && above_hi;
            if (sample_valid) begin
                if (above_hi) begin
                    lvl       <= 1'b1;
                    lvl_known <= 1'b1;
                end else if (below_lo) begin
                    lvl       <= 1'b0;
                    lvl_known <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= SEEK;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        per_inc     = 1'b0;
        div_start   = 1'b0;
        timeout_hit = 1'b0;
        result_ld   = 1'b0;
        case (state)
            SEEK: begin
                if (evt_p1) begin
                    cnt_clr   = 1'b1;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (vld_p1) begin
                    cnt_inc = 1'b1;
                    per_inc = evt_p1;
                    // A timeout wins over a final event on the same sample.
                    if (cnt_nxt == TIMEOUT) begin
                        timeout_hit = 1'b1;
                        state_nxt   = SEEK;
                    end else if (evt_p1 && per_nxt == PER_W'(NAVG)) begin
                        div_start = 1'b1;
                        state_nxt = DIV;
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    result_ld = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = SEEK;
            default: state_nxt = SEEK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            per        <= '0;
            step_out   <= '0;
            step_valid <= 1'b0;
            no_signal  <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            if (cnt_clr) begin
                cnt <= '0;
                per <= '0;
            end else begin
                if (cnt_inc)
                    cnt <= cnt_nxt;
                if (per_inc)
                    per <= per_nxt;
            end
            if (timeout_hit) begin
                step_out   <= '0;
                no_signal  <= 1'b1;
                step_valid <= 1'b1;
            end
            if (result_ld) begin
                step_out   <= sat_step(quotient);
                no_signal  <= 1'b0;
                step_valid <= 1'b1;
            end
        end
    end

    dds_restoring_div #(
        .DVD_W(DVD_W),
        .DVS_W(STEP_W)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .start   (div_start),
        .dividend(dividend),
        .divisor (cnt_nxt),
        .done    (div_done),
        .quotient(quotient)
    );
endmodule

// File: tb/tb_dds_step_estimator.sv
// Directed bench: two estimator instances (single-period with short timeout,
// and 4-period averaging) driven from shared waveform tables.
module tb_dds_step_estimator;
    import dds_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sample_in = 16'h8000;
    logic        sample_valid = 1'b0;

    logic [31:0] step_out0;
    logic        step_valid0;
    logic        no_signal0;
    logic        busy0;
    logic [31:0] step_outA;
    logic        step_validA;
    logic        no_signalA;
    logic        busyA;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int drv_cyc = 0;

    int          pcyc0[$];
    logic [31:0] pval0[$];
    logic        pns0[$];
    int          pcycA[$];
    logic [31:0] pvalA[$];
    logic        pnsA[$];
    logic        prev0 = 1'b0;
    logic        prevA = 1'b0;
    int          consec0 = 0;
    int          consecA = 0;

    dds_step_estimator #(.AVG_LOG2(0), .TIMEOUT(32'd1000)) u_dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .step_out(step_out0), .step_valid(step_valid0), .no_signal(no_signal0), .busy(busy0)
    );

    dds_step_estimator #(.AVG_LOG2(2)) u_avg (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .step_out(step_outA), .step_valid(step_validA), .no_signal(no_signalA), .busy(busyA)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (step_valid0) begin
            pcyc0.push_back(cyc);
            pval0.push_back(step_out0);
            pns0.push_back(no_signal0);
        end
        if (step_validA) begin
            pcycA.push_back(cyc);
            pvalA.push_back(step_outA);
            pnsA.push_back(no_signalA);
        end
        if (step_valid0 && prev0) consec0 <= consec0 + 1;
        if (step_validA && prevA) consecA <= consecA + 1;
        prev0 <= step_valid0;
        prevA <= step_validA;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int sel, input int base,
                           input logic [31:0] exp_step, input logic exp_ns);
        int          n;
        logic [31:0] v;
        logic        ns_v;
        n = (sel == 0) ? pval0.size() : pvalA.size();
        chk({tag, "_got"}, 64'(n > base), 64'd1);
        if (n > base) begin
            v    = (sel == 0) ? pval0[base] : pvalA[base];
            ns_v = (sel == 0) ? pns0[base] : pnsA[base];
            chk({tag, "_step"}, 64'(v), 64'(exp_step));
            chk({tag, "_ns"}, 64'(ns_v), 64'(exp_ns));
        end
    endtask

    task automatic drive(input logic [15:0] s, input logic v);
        @(posedge clk);
        #1;
        sample_in    = s;
        sample_valid = v;
        drv_cyc      = cyc;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 16'h8000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [15:0] wave(input int kind, input int k);
        logic [31:0] ph;
        logic [15:0] w;
        real         r;
        int          m;
        w = 16'h8000;
        case (kind)
            0: begin
                ph = 32'(k) << 24;
                w  = ph[31] ? ~{ph[30:16], 1'b0} : {ph[30:16], 1'b0};
            end
            1: begin
                r = 32768.0 + 30000.0 * $sin(6.283185307179586 * real'(k % 100) / 100.0);
                w = 16'(int'(r));
            end
            2: begin
                m = k % 64;
                if (m == 0 || m == 33)      w = 16'h8200;
                else if (m == 1 || m == 32) w = 16'h7E00;
                else if (m < 32)            w = 16'hE000;
                else                        w = 16'h2000;
            end
            3: w = ((k % 128) < 64) ? 16'hE000 : 16'h2000;
            default: w = 16'h8000;
        endcase
        return w;
    endfunction

    initial begin
        int b0, bA, t201, t501, idx, got_busy;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_step", 64'(step_out0), 64'd0);
        chk("rst_valid", 64'(step_valid0), 64'd0);
        chk("rst_nosig", 64'(no_signal0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_state", 64'(u_dut.state), 64'(SEEK));
        chk("rst_step_avg", 64'(step_outA), 64'd0);

        // Triangle, period 256
        b0 = pval0.size();
        for (int k = 0; k < 700; k++) drive(wave(0, k), 1'b1);
        chk_res("tri", 0, b0, 32'h0100_0000, 1'b0);

        // Sine, period 100, single and 4-period average with latency
        do_reset();
        b0 = pval0.size();
        bA = pvalA.size();
        t201 = 0;
        t501 = 0;
        for (int k = 0; k < 600; k++) begin
            drive(wave(1, k), 1'b1);
            if (k == 201) t201 = drv_cyc;
            if (k == 501) t501 = drv_cyc;
        end
        chk_res("sine", 0, b0, 32'h028F_5C28, 1'b0);
        chk_res("sine_avg", 1, bA, 32'h028F_5C28, 1'b0);
        if (pcyc0.size() > b0) chk("sine_lat", 64'(pcyc0[b0] - t201), 64'd35);
        if (pcycA.size() > bA) chk("sine_avg_lat", 64'(pcycA[bA] - t501), 64'd37);

        // Square with glitches inside the hysteresis band, period 64
        do_reset();
        b0 = pval0.size();
        bA = pvalA.size();
        for (int k = 0; k < 500; k++) drive(wave(2, k), 1'b1);
        chk_res("glitch", 0, b0, 32'h0400_0000, 1'b0);
        chk_res("glitch_avg", 1, bA, 32'h0400_0000, 1'b0);

        // Timeout after exactly 1000 valid samples following the arming event
        do_reset();
        b0 = pval0.size();
        drive(16'h2000, 1'b1);
        drive(16'hE000, 1'b1);
        for (int k = 0; k < 999; k++) drive(16'h8000, 1'b1);
        for (int k = 0; k < 5; k++) drive(16'h8000, 1'b0);
        chk("tmo_early", 64'(pval0.size()), 64'(b0));
        drive(16'h8000, 1'b1);
        for (int k = 0; k < 3; k++) drive(16'h8000, 1'b0);
        chk("tmo_count", 64'(pval0.size()), 64'(b0 + 1));
        chk_res("tmo", 0, b0, 32'h0000_0000, 1'b1);
        chk("tmo_nosig_hold", 64'(no_signal0), 64'd1);
        b0 = pval0.size();
        for (int k = 0; k < 700; k++) drive(wave(0, k), 1'b1);
        chk_res("recover", 0, b0, 32'h0100_0000, 1'b0);

        // Gapped valid, period 128 valid samples
        do_reset();
        b0 = pval0.size();
        bA = pvalA.size();
        idx = 0;
        for (int j = 0; j < 3000 && idx < 760; j++) begin
            if (j % 3 == 1) drive(16'h0000, 1'b0);
            else begin
                drive(wave(3, idx), 1'b1);
                idx++;
            end
        end
        chk_res("gaps", 0, b0, 32'h0200_0000, 1'b0);
        chk_res("gaps_avg", 1, bA, 32'h0200_0000, 1'b0);

        // Reset in the middle of a division
        got_busy = 0;
        for (int k = 0; k < 2000; k++) begin
            drive(wave(0, k), 1'b1);
            if (busy0) begin
                got_busy = 1;
                break;
            end
        end
        chk("mid_busy_seen", 64'(got_busy), 64'd1);
        for (int k = 0; k < 5; k++) drive(16'h8000, 1'b0);
        chk("mid_busy_before", 64'(busy0), 64'd1);
        b0 = pval0.size();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_step", 64'(step_out0), 64'd0);
        chk("mid_busy", 64'(busy0), 64'd0);
        chk("mid_valid", 64'(step_valid0), 64'd0);
        chk("mid_nosig", 64'(no_signal0), 64'd0);
        chk("mid_state", 64'(u_dut.state), 64'(SEEK));
        #1;
        reset = 1'b1;
        for (int k = 0; k < 60; k++) drive(16'h8000, 1'b0);
        chk("mid_no_pulse", 64'(pval0.size()), 64'(b0));

        chk("b2b_single", 64'(consec0), 64'd0);
        chk("b2b_avg", 64'(consecA), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dds_step_estimator.md
# dds_step_estimator

Measures the fundamental period of an incoming 16-bit offset-binary waveform (ADC capture or DDS loopback) and reports the equivalent 32-bit DDS frequency tuning word, Step = 2^32 / period_in_samples. It is the receive-side counterpart of the phase-accumulator wave generators: it closes the loop for self-test and frequency tracking, and its Step output feeds straight back into a generator's Step input. It uses a hysteresis zero-crossing detector, a period counter with optional averaging, and a sequential restoring divider.

## Interface
- MIDPOINT, 16'h8000: waveform centre level (offset binary).
- HYST, 16'h0400: hysteresis half-width around MIDPOINT.
- AVG_LOG2, 0: number of periods averaged per result, 2^AVG_LOG2; legal range 0..4.
- TIMEOUT, 32'd50_000_000: maximum valid samples per measurement before no-signal.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- sample_in  in  16  waveform sample, offset binary.
- sample_valid  in  1  sample_in qualifier; only qualified samples are counted.
- step_out  out  32  latest tuning word; holds between results.
- step_valid  out  1  one-cycle pulse when step_out updates.
- no_signal  out  1  set by a timeout, cleared by the next successful result.
- busy  out  1  high in DIV.

## Operation
- Comparator flag lvl, plus lvl_known. On a valid sample: if sample_in >= MIDPOINT+HYST, lvl=1; if sample_in <= MIDPOINT-HYST, lvl=0; otherwise hold. Both thresholds saturate to 16-bit range.
- Rising event: a valid sample that drives lvl 0→1 while lvl_known=1. The first sample that sets lvl_known never produces an event.
- FSM states SEEK, COUNT, DIV, DONE; reset state is SEEK.
- SEEK: on an event, cnt<=0, per<=0, go to COUNT.
- COUNT: each valid sample does cnt<=cnt+1. On an event, per<=per+1. If per+1 == 2^AVG_LOG2, latch divisor = cnt+1 and go to DIV. cnt therefore counts samples from the one after the start event through the end event, inclusive.
- Timeout: in COUNT with cnt+1 == TIMEOUT, step_out<=0, no_signal<=1, one step_valid pulse, return to SEEK. A timeout takes priority over a coincident final event.
- DIV: restoring division of dividend 2^(32+AVG_LOG2) by divisor, one quotient bit per cycle, 33+AVG_LOG2 cycles. Input samples are ignored. If the quotient is >= 2^32 (divisor <= 2^AVG_LOG2), saturate to 32'hFFFF_FFFF. The quotient is truncated, not rounded.
- DONE: step_out<=quotient, no_signal<=0, step_valid pulses for this cycle, next state SEEK.
- Reset at any time: step_out=0, step_valid=0, no_signal=0, busy=0, lvl_known=0, cnt=per=0, state SEEK. An in-flight division is discarded.

## Timing
- Event detection is registered: the event is seen on the cycle after the valid sample arrives.
- Latency from the final event sample to step_valid is 35+AVG_LOG2 cycles: 1 for detection, 33+AVG_LOG2 for DIV, 1 for DONE.
- Measurements are not back-to-back. After DONE, the next measurement starts at the next rising event in SEEK.
- step_valid is never asserted for two consecutive cycles.
- sample_valid may be low for any number of cycles. Gaps do not advance cnt.

## Structure
- Shared package dds_pkg holds: STEP_W=32, SAMPLE_W=16, the state enum, and the saturation constant.
- The natural sub-module is dds_restoring_div: parameterised dividend and divisor widths, with start/done handshake and a fixed iteration count. The comparator and FSM stay in the top level.

## Test plan
- Triangle from a DDS generator with Step=32'h0100_0000, sample_valid=1 continuously (period 256) → step_out=32'h0100_0000, step_valid pulse, no_signal=0.
- Sampled sine with period 100, AVG_LOG2=0 → step_out=32'h028F_5C28 (truncated). With AVG_LOG2=2 → the same value, with step_valid 37 cycles after the 4th event sample.
- Noisy square around MIDPOINT, ±HYST/2 glitches at each edge, period 64 → exactly one event per period, step_out=32'h0400_0000.
- Constant input 16'h8000 with TIMEOUT=1000 → 1000 valid samples after the arming event; step_out=0, no_signal=1. A following valid period-256 signal clears no_signal.
- sample_valid toggling 1-0-1 with period 128 valid samples → step_out=32'h0200_0000, independent of the gaps.
- Reset asserted mid-DIV → the next cycle shows step_out=0, busy=0, no step_valid pulse, and state SEEK.
